// File: rtl/fetch_pc_if.sv
// Fetch PC unit bus: predictor/BTB lookup results, execute-stage resolve,
// and the redirect/training outputs back to the front end.
interface fetch_pc_if #(
  parameter int unsigned PCSIZE = 16
);
  logic              stall;
  logic              is_branch;
  logic              pred_taken;
  logic              btb_hit;
  logic [PCSIZE-1:0] btb_target;
  logic              resolve_valid;
  logic              resolve_taken;
  logic [PCSIZE-1:0] resolve_target;
  logic [PCSIZE-1:0] pc_f;
  logic              flush;
  logic [2:0]        upd_branch;
  logic [PCSIZE-1:0] pc_update;
  logic              outcome;
  logic [PCSIZE-1:0] upd_target;
  logic              q_full;
  logic              resolve_err;

  modport master (
    output stall, is_branch, pred_taken, btb_hit, btb_target,
           resolve_valid, resolve_taken, resolve_target,
    input  pc_f, flush, upd_branch, pc_update, outcome, upd_target,
           q_full, resolve_err
  );

  modport slave (
    input  stall, is_branch, pred_taken, btb_hit, btb_target,
           resolve_valid, resolve_taken, resolve_target,
    output pc_f, flush, upd_branch, pc_update, outcome, upd_target,
           q_full, resolve_err
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC generator: next-PC selection, in-order queue of predicted
// branches awaiting resolve, mispredict redirect/flush, predictor training.
module fetch_pc_unit #(
  parameter int unsigned       PCSIZE  = 16,
  parameter int unsigned       DEPTH   = 4,
  parameter logic [PCSIZE-1:0] RESETPC = '0
) (
  input logic         clk,
  input logic         rst_n,
  fetch_pc_if.slave   bus
);
  localparam int unsigned       PTRW = $clog2(DEPTH);
  localparam int unsigned       CW   = PTRW + 1;
  localparam logic [PCSIZE-1:0] FOUR = PCSIZE'(4);

  logic [PCSIZE-1:0] pc_q, pc_d;
  logic [PTRW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PCSIZE-1:0] qpc_q  [DEPTH];
  logic [PCSIZE-1:0] qpc_d  [DEPTH];
  logic              qtake_q[DEPTH];
  logic              qtake_d[DEPTH];
  logic [PCSIZE-1:0] qtgt_q [DEPTH];
  logic [PCSIZE-1:0] qtgt_d [DEPTH];
  logic              flush_q, flush_d;
  logic              updv_q, updv_d;
  logic [PCSIZE-1:0] pc_update_q, pc_update_d;
  logic              outcome_q, outcome_d;
  logic [PCSIZE-1:0] upd_target_q, upd_target_d;
  logic              err_q, err_d;

  logic              take, q_empty, q_full, pop, push, mispredict, full_block;
  logic [PCSIZE-1:0] pc_plus4, head_pc, head_tgt, correct_pc;
  logic              head_take;

  // Prediction, queue status, mispredict detection and next-state selection
  always_comb begin
    take       = bus.is_branch & bus.pred_taken & bus.btb_hit;
    pc_plus4   = pc_q + FOUR;
    q_empty    = (count_q == '0);
    q_full     = (count_q == CW'(DEPTH));
    head_pc    = qpc_q[head_q];
    head_take  = qtake_q[head_q];
    head_tgt   = qtgt_q[head_q];
    pop        = bus.resolve_valid & ~q_empty;
    mispredict = pop & ((bus.resolve_taken != head_take) |
                        (bus.resolve_taken & (bus.resolve_target != head_tgt)));
    correct_pc = bus.resolve_taken ? bus.resolve_target : (head_pc + FOUR);
    // A same-cycle pop frees a slot, so a full queue only blocks without one
    full_block = q_full & ~pop;
    push       = bus.is_branch & ~bus.stall & ~full_block & ~mispredict;

    pc_d = pc_plus4;
    if (mispredict)                       pc_d = correct_pc;
    else if (bus.stall)                   pc_d = pc_q;
    else if (bus.is_branch && full_block) pc_d = pc_q;
    else if (take)                        pc_d = bus.btb_target;

    qpc_d   = qpc_q;
    qtake_d = qtake_q;
    qtgt_d  = qtgt_q;
    if (push) begin
      qpc_d[tail_q]   = pc_q;
      qtake_d[tail_q] = take;
      qtgt_d[tail_q]  = take ? bus.btb_target : pc_plus4;
    end

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (mispredict) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end

    flush_d      = mispredict;
    updv_d       = pop;
    pc_update_d  = pop ? head_pc : pc_update_q;
    outcome_d    = pop ? bus.resolve_taken : outcome_q;
    upd_target_d = pop ? bus.resolve_target : upd_target_q;
    err_d        = err_q | (bus.resolve_valid & q_empty);
  end

  // State registers, all cleared by asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESETPC;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        qpc_q[i]   <= '0;
        qtake_q[i] <= 1'b0;
        qtgt_q[i]  <= '0;
      end
      flush_q      <= 1'b0;
      updv_q       <= 1'b0;
      pc_update_q  <= '0;
      outcome_q    <= 1'b0;
      upd_target_q <= '0;
      err_q        <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      qpc_q        <= qpc_d;
      qtake_q      <= qtake_d;
      qtgt_q       <= qtgt_d;
      flush_q      <= flush_d;
      updv_q       <= updv_d;
      pc_update_q  <= pc_update_d;
      outcome_q    <= outcome_d;
      upd_target_q <= upd_target_d;
      err_q        <= err_d;
    end
  end

  assign bus.pc_f        = pc_q;
  assign bus.flush       = flush_q;
  assign bus.upd_branch  = {2'b00, updv_q};
  assign bus.pc_update   = pc_update_q;
  assign bus.outcome     = outcome_q;
  assign bus.upd_target  = upd_target_q;
  assign bus.q_full      = q_full;
  assign bus.resolve_err = err_q;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit (PCSIZE=16, DEPTH=4, RESETPC=0).
module tb_fetch_pc_unit;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fetch_pc_if #(.PCSIZE(16)) bus ();

  fetch_pc_unit #(.PCSIZE(16), .DEPTH(4), .RESETPC(16'h0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.stall          = 1'b0;
    bus.is_branch      = 1'b0;
    bus.pred_taken     = 1'b0;
    bus.btb_hit        = 1'b0;
    bus.btb_target     = '0;
    bus.resolve_valid  = 1'b0;
    bus.resolve_taken  = 1'b0;
    bus.resolve_target = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic branch(input logic taken, input logic [15:0] tgt);
    bus.is_branch  = 1'b1;
    bus.pred_taken = taken;
    bus.btb_hit    = 1'b1;
    bus.btb_target = tgt;
  endtask

  task automatic resolve(input logic taken, input logic [15:0] tgt);
    bus.resolve_valid  = 1'b1;
    bus.resolve_taken  = taken;
    bus.resolve_target = tgt;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", bus.pc_f, 16'h0000);
    chk("rst_flush", bus.flush, 1'b0);
    chk("rst_upd", bus.upd_branch, 3'b000);
    chk("rst_pcupd", bus.pc_update, 16'h0000);
    chk("rst_outcome", bus.outcome, 1'b0);
    chk("rst_updtgt", bus.upd_target, 16'h0000);
    chk("rst_qfull", bus.q_full, 1'b0);
    chk("rst_err", bus.resolve_err, 1'b0);
    rst_n = 1'b1;

    tick(); chk("run_pc4", bus.pc_f, 16'h0004);
    tick(); chk("run_pc8", bus.pc_f, 16'h0008);
    tick(); chk("run_pcC", bus.pc_f, 16'h000C);
    rst_n = 1'b0;
    #1;
    chk("midrst_pc", bus.pc_f, 16'h0000);
    chk("midrst_flush", bus.flush, 1'b0);
    #1;
    rst_n = 1'b1;

    // correctly predicted taken branch
    repeat (4) tick();
    chk("run_pc10", bus.pc_f, 16'h0010);
    branch(1'b1, 16'h0040);
    tick(); chk("tk_pc", bus.pc_f, 16'h0040);
    idle(); resolve(1'b1, 16'h0040);
    tick();
    chk("tk_pc_after", bus.pc_f, 16'h0044);
    chk("tk_flush", bus.flush, 1'b0);
    chk("tk_upd", bus.upd_branch, 3'b001);
    chk("tk_pcupd", bus.pc_update, 16'h0010);
    chk("tk_outcome", bus.outcome, 1'b1);
    chk("tk_updtgt", bus.upd_target, 16'h0040);
    idle();
    tick();
    chk("tk_upd_clr", bus.upd_branch, 3'b000);
    chk("tk_pcupd_hold", bus.pc_update, 16'h0010);
    chk("tk_pc2", bus.pc_f, 16'h0048);
    chk("tk_err", bus.resolve_err, 1'b0);

    // predicted not-taken, actually taken
    do_reset();
    repeat (4) tick();
    branch(1'b0, 16'h0040);
    tick(); chk("nt_pc", bus.pc_f, 16'h0014);
    idle(); resolve(1'b1, 16'h0080);
    tick();
    chk("ntt_flush", bus.flush, 1'b1);
    chk("ntt_pc", bus.pc_f, 16'h0080);
    chk("ntt_upd", bus.upd_branch, 3'b001);
    chk("ntt_pcupd", bus.pc_update, 16'h0010);
    chk("ntt_updtgt", bus.upd_target, 16'h0080);
    idle();
    tick();
    chk("ntt_flush_clr", bus.flush, 1'b0);
    chk("ntt_pc2", bus.pc_f, 16'h0084);

    // resolve against the now-empty queue
    resolve(1'b1, 16'h0300);
    tick();
    chk("empty_err", bus.resolve_err, 1'b1);
    chk("empty_upd", bus.upd_branch, 3'b000);
    chk("empty_pc", bus.pc_f, 16'h0088);
    chk("empty_pcupd", bus.pc_update, 16'h0010);
    chk("empty_updtgt", bus.upd_target, 16'h0080);
    chk("empty_flush", bus.flush, 1'b0);
    idle();
    tick();
    chk("err_sticky", bus.resolve_err, 1'b1);
    chk("err_pc", bus.pc_f, 16'h008C);

    // predicted taken, actually not taken
    do_reset();
    chk("err_cleared", bus.resolve_err, 1'b0);
    repeat (4) tick();
    branch(1'b1, 16'h0040);
    tick(); chk("tnt_pc", bus.pc_f, 16'h0040);
    idle(); resolve(1'b0, 16'h0099);
    tick();
    chk("tnt_flush", bus.flush, 1'b1);
    chk("tnt_pc_redir", bus.pc_f, 16'h0014);
    chk("tnt_upd", bus.upd_branch, 3'b001);
    chk("tnt_outcome", bus.outcome, 1'b0);
    chk("tnt_updtgt", bus.upd_target, 16'h0099);
    chk("tnt_pcupd", bus.pc_update, 16'h0010);
    idle();
    tick();
    chk("tnt_pc2", bus.pc_f, 16'h0018);
    chk("tnt_flush_clr", bus.flush, 1'b0);

    // taken with wrong target
    branch(1'b1, 16'h0040);
    tick(); chk("wt_pc", bus.pc_f, 16'h0040);
    idle(); resolve(1'b1, 16'h0060);
    tick();
    chk("wt_pc_redir", bus.pc_f, 16'h0060);
    chk("wt_flush", bus.flush, 1'b1);
    chk("wt_pcupd", bus.pc_update, 16'h0018);
    idle();

    // fill the queue with not-taken branches
    do_reset();
    branch(1'b0, 16'h0000);
    tick(); chk("fill1_pc", bus.pc_f, 16'h0004);
    tick(); chk("fill2_pc", bus.pc_f, 16'h0008);
    tick(); chk("fill3_qfull", bus.q_full, 1'b0);
    tick();
    chk("fill4_pc", bus.pc_f, 16'h0010);
    chk("fill4_qfull", bus.q_full, 1'b1);
    tick();
    chk("full_hold_pc", bus.pc_f, 16'h0010);
    chk("full_hold_qfull", bus.q_full, 1'b1);
    resolve(1'b0, 16'h0000);
    tick();
    chk("full_pp_pc", bus.pc_f, 16'h0014);
    chk("full_pp_qfull", bus.q_full, 1'b1);
    chk("full_pp_upd", bus.upd_branch, 3'b001);
    chk("full_pp_pcupd", bus.pc_update, 16'h0000);
    chk("full_pp_flush", bus.flush, 1'b0);
    bus.resolve_valid = 1'b0;
    tick();
    chk("full_pp_hold", bus.pc_f, 16'h0014);
    idle(); resolve(1'b0, 16'h0000);
    tick();
    chk("drain1_pc", bus.pc_f, 16'h0018);
    chk("drain1_pcupd", bus.pc_update, 16'h0004);
    chk("drain1_qfull", bus.q_full, 1'b0);
    chk("drain1_flush", bus.flush, 1'b0);
    tick(); chk("drain2_pcupd", bus.pc_update, 16'h0008);
    tick(); chk("drain3_pcupd", bus.pc_update, 16'h000C);
    tick();
    chk("drain4_pcupd", bus.pc_update, 16'h0010);
    chk("drain4_flush", bus.flush, 1'b0);
    tick();
    chk("drain5_upd", bus.upd_branch, 3'b000);
    chk("drain5_err", bus.resolve_err, 1'b1);
    idle();

    // stall behaviour
    do_reset();
    repeat (2) tick();
    branch(1'b1, 16'h0040);
    tick(); chk("st_pc", bus.pc_f, 16'h0040);
    idle(); bus.stall = 1'b1;
    tick(); chk("st_hold1", bus.pc_f, 16'h0040);
    tick(); chk("st_hold2", bus.pc_f, 16'h0040);
    resolve(1'b1, 16'h0040);
    tick();
    chk("st_hold3", bus.pc_f, 16'h0040);
    chk("st_upd", bus.upd_branch, 3'b001);
    chk("st_pcupd", bus.pc_update, 16'h0008);
    chk("st_flush", bus.flush, 1'b0);
    idle(); branch(1'b0, 16'h0000);
    tick(); chk("st_push_pc", bus.pc_f, 16'h0044);
    idle(); bus.stall = 1'b1; resolve(1'b1, 16'h0200);
    tick();
    chk("st_redir_pc", bus.pc_f, 16'h0200);
    chk("st_redir_flush", bus.flush, 1'b1);
    chk("st_redir_pcupd", bus.pc_update, 16'h0040);
    bus.resolve_valid = 1'b0;
    tick();
    chk("st_after_pc", bus.pc_f, 16'h0200);
    chk("st_after_flush", bus.flush, 1'b0);
    chk("st_after_upd", bus.upd_branch, 3'b000);

    // PC wrap at the top of the address space
    idle(); branch(1'b0, 16'h0000);
    tick(); chk("wr_push_pc", bus.pc_f, 16'h0204);
    idle(); resolve(1'b1, 16'hFFF8);
    tick(); chk("wr_redir", bus.pc_f, 16'hFFF8);
    idle();
    tick(); chk("wr_fffc", bus.pc_f, 16'hFFFC);
    tick(); chk("wr_zero", bus.pc_f, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
